// File: rtl/sha3_pkg.sv
// sha3_pkg
//   Types and constants shared by the Keccak-f[1600] lane packer and the
//   permutation round stages.
//   LANES / LANE_W : lane count and lane width of the 5x5 state
//   lane_t         : one 64-bit lane
//   plane_t        : one row of five lanes, index [0:4] = x
//   pack_state_e   : lane packer state (FILL, FULL)
package sha3_pkg;

    localparam int LANES  = 25;
    localparam int LANE_W = 64;
    localparam int ROWS   = 5;

    typedef logic [LANE_W-1:0] lane_t;
    typedef lane_t plane_t [0:4];

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } pack_state_e;

    // Fill-slot number of the lane at row r, column c (arrival order k = 5*r + c).
    function automatic logic [4:0] slot_index(input int r, input int c);
        return 5'(r * ROWS + c);
    endfunction

endpackage

// File: rtl/sha3_lane_packer.sv
// sha3_lane_packer
//   Packs a stream of 64-bit lanes into a 25-lane fill buffer and presents
//   the complete 5x5 state on five row buses with a one-cycle sample strobe.
//   The presented rows are a separate register bank, so the next state can
//   fill while the previous one is held stable.
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_data/in_valid  : lane stream, lane k lands at row k/5, column k%5
//   in_last           : final lane of the current state, rest zero-filled
//   in_ready          : lane accepted when in_valid && in_ready
//   hold              : downstream not ready, defers presentation
//   osa..ose          : row buses a..e (rows 0..4), index [0:4] = x
//   sample            : one-cycle strobe, rows are new in that cycle
module sha3_lane_packer
    import sha3_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  lane_t  in_data,
    input  logic   in_valid,
    input  logic   in_last,
    output logic   in_ready,
    input  logic   hold,
    output plane_t osa,
    output plane_t osb,
    output plane_t osc,
    output plane_t osd,
    output plane_t ose,
    output logic   sample
);

    pack_state_e state_r;
    logic [4:0]  cnt_r;
    logic        in_ready_r;
    logic        sample_r;
    plane_t      fill_r [0:4];
    plane_t      out_r  [0:4];

    logic        xfer_s;
    logic        done_s;

    // Handshake and end-of-state detection for the current beat.
    always_comb begin
        xfer_s = in_valid && in_ready_r;
        done_s = xfer_s && (in_last || (cnt_r == 5'd24));
    end

    // Packer FSM: fill slots in FILL, hand the buffer to the output bank in FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= FILL;
            cnt_r      <= 5'd0;
            in_ready_r <= 1'b1;
            sample_r   <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < ROWS; c++) begin
                    fill_r[r][c] <= 64'd0;
                    out_r[r][c]  <= 64'd0;
                end
            end
        end else begin
            case (state_r)
                FILL: begin
                    sample_r <= 1'b0;
                    if (xfer_s) begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < ROWS; c++) begin
                                if (cnt_r == slot_index(r, c)) begin
                                    fill_r[r][c] <= in_data;
                                end
                            end
                        end
                        // cnt stays at the last written slot while FULL;
                        // it is cleared when the state is handed over.
                        if (done_s) begin
                            state_r    <= FULL;
                            in_ready_r <= 1'b0;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                end
                FULL: begin
                    if (!hold) begin
                        // Present the state and clear the buffer so a short
                        // next state cannot expose stale lanes.
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < ROWS; c++) begin
                                out_r[r][c]  <= fill_r[r][c];
                                fill_r[r][c] <= 64'd0;
                            end
                        end
                        sample_r   <= 1'b1;
                        cnt_r      <= 5'd0;
                        state_r    <= FILL;
                        in_ready_r <= 1'b1;
                    end else begin
                        sample_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= FILL;
                    cnt_r      <= 5'd0;
                    in_ready_r <= 1'b1;
                    sample_r   <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign sample   = sample_r;
    assign osa      = out_r[0];
    assign osb      = out_r[1];
    assign osc      = out_r[2];
    assign osd      = out_r[3];
    assign ose      = out_r[4];

endmodule

// File: tb/tb_sha3_lane_packer.sv
// tb_sha3_lane_packer
//   Directed and randomised stimulus for sha3_lane_packer. A reference model
//   keeps the lanes of each state as a flat list, zero-fills short states and
//   predicts presentation from "state complete" plus the hold input.
module tb_sha3_lane_packer;
    import sha3_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    lane_t  in_data;
    logic   in_valid;
    logic   in_last;
    logic   in_ready;
    logic   hold;
    plane_t osa, osb, osc, osd, ose;
    logic   sample;

    sha3_lane_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .hold     (hold),
        .osa      (osa),
        .osb      (osb),
        .osc      (osc),
        .osd      (osd),
        .ose      (ose),
        .sample   (sample)
    );

    always #5 clk = ~clk;

    // reference model state
    lane_t       cur [25];
    int          cur_n;
    bit          full_m;
    lane_t       expq [$];
    lane_t       exp_rows [25];
    int          cyc;
    int          samp_cyc [$];
    logic [64:0] tx [$];
    int          total;
    int          bad;

    function automatic lane_t dut_lane(input int k);
        case (k / 5)
            0:       return osa[k % 5];
            1:       return osb[k % 5];
            2:       return osc[k % 5];
            3:       return osd[k % 5];
            4:       return ose[k % 5];
            default: return 64'hx;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cur_n  = 0;
        full_m = 1'b0;
        expq.delete();
        for (int k = 0; k < 25; k++) exp_rows[k] = 64'd0;
    endtask

    task automatic accept(input lane_t d, input logic last);
        cur[cur_n] = d;
        cur_n++;
        if (cur_n == 25 || last) begin
            for (int k = 0; k < 25; k++) expq.push_back((k < cur_n) ? cur[k] : 64'd0);
            cur_n  = 0;
            full_m = 1'b1;
        end
    endtask

    task automatic check_rows(input string tag);
        for (int k = 0; k < 25; k++) chk($sformatf("%s[%0d]", tag, k), dut_lane(k), exp_rows[k]);
    endtask

    // One clock: predict what the edge does, then compare the DUT just after it.
    task automatic tick(output bit xfer);
        bit h;
        bit es;
        xfer = in_valid && !full_m;
        h    = hold;
        @(posedge clk);
        #1;
        cyc++;
        es = full_m && !h;
        if (es) begin
            full_m = 1'b0;
            for (int k = 0; k < 25; k++) exp_rows[k] = expq.pop_front();
            samp_cyc.push_back(cyc);
        end
        if (xfer) accept(in_data, in_last);
        chk("sample", {63'd0, sample}, {63'd0, es});
        chk("in_ready", {63'd0, in_ready}, {63'd0, !full_m});
        check_rows("row");
    endtask

    task automatic run_tx(input int gap_pct, input int hold_pct);
        int budget;
        bit x;
        budget = 3000;
        while (tx.size() > 0 && budget > 0) begin
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom};
                in_last  = 1'($urandom_range(1));
            end else begin
                in_valid = 1'b1;
                in_data  = tx[0][63:0];
                in_last  = tx[0][64];
            end
            hold = ($urandom_range(99) < hold_pct);
            tick(x);
            if (x) void'(tx.pop_front());
            budget--;
        end
        chk("tx_budget", 64'(tx.size()), 64'd0);
        tx.delete();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int budget;
        bit x;
        budget = 100;
        hold   = 1'b0;
        in_valid = 1'b0;
        while ((full_m || expq.size() > 0) && budget > 0) begin
            tick(x);
            budget--;
        end
        chk("drain", 64'(expq.size()), 64'd0);
        repeat (2) tick(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_sample", {63'd0, sample}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        model_reset();
        check_rows("rst_row");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bit x;
        int n;
        total    = 0;
        bad      = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        in_data  = 64'd0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        hold     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_sample", {63'd0, sample}, 64'd0);
        check_rows("reset_row");
        repeat (3) tick(x);

        // two full states back to back, lanes 0..24
        samp_cyc.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 25; k++) tx.push_back({1'b0, 64'(k)});
        run_tx(0, 0);
        drain();
        chk("full_strobes", 64'(samp_cyc.size()), 64'd2);
        chk("full_spacing", (samp_cyc.size() >= 2) ? 64'(samp_cyc[1] - samp_cyc[0]) : 64'd0, 64'd26);
        chk("full_osa0", osa[0], 64'd0);
        chk("full_ose4", ose[4], 64'd24);

        // two 17-lane states ending with in_last
        samp_cyc.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 17; k++) tx.push_back({(k == 16), 64'hA5A5_0000_0000_0000 | 64'(k)});
        run_tx(0, 0);
        drain();
        chk("last17_strobes", 64'(samp_cyc.size()), 64'd2);
        chk("last17_spacing", (samp_cyc.size() >= 2) ? 64'(samp_cyc[1] - samp_cyc[0]) : 64'd0, 64'd18);
        chk("last17_osd2", osd[2], 64'd0);
        chk("last17_osd1", osd[1], 64'hA5A5_0000_0000_0010);

        // hold across a complete fill, then release
        samp_cyc.delete();
        for (int k = 0; k < 25; k++) tx.push_back({1'b0, 64'h1000 + 64'(k)});
        run_tx(0, 100);
        repeat (10) tick(x);
        chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
        chk("hold_nostrobe", 64'(samp_cyc.size()), 64'd0);
        hold = 1'b0;
        tick(x);
        chk("hold_release", 64'(samp_cyc.size()), 64'd1);
        chk("hold_ose4", ose[4], 64'h1018);
        drain();

        // all-ones state then a single-lane state: no stale lanes
        samp_cyc.delete();
        for (int k = 0; k < 25; k++) tx.push_back({1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        tx.push_back({1'b1, 64'h1});
        run_tx(0, 0);
        drain();
        chk("one_spacing", (samp_cyc.size() >= 2) ? 64'(samp_cyc[1] - samp_cyc[0]) : 64'd0, 64'd2);
        chk("one_osa0", osa[0], 64'd1);
        chk("one_ose4", ose[4], 64'd0);

        // randomised gaps, hold and lengths over 4 states
        samp_cyc.delete();
        for (int s = 0; s < 4; s++) begin
            n = $urandom_range(25, 1);
            for (int k = 0; k < n; k++)
                tx.push_back({(k == n - 1) ? 1'($urandom_range(1)) | (n < 25) : 1'b0, {$urandom, $urandom}});
        end
        run_tx(50, 30);
        drain();
        chk("rand_strobes", 64'(samp_cyc.size()), 64'd4);

        // reset in the middle of a fill
        for (int k = 0; k < 12; k++) tx.push_back({1'b0, 64'hDEAD_0000 + 64'(k)});
        run_tx(0, 0);
        do_reset();
        samp_cyc.delete();
        for (int k = 0; k < 25; k++) tx.push_back({1'b0, 64'hBEEF_0000 + 64'(k)});
        run_tx(0, 0);
        drain();
        chk("post_rst_strobes", 64'(samp_cyc.size()), 64'd1);
        chk("post_rst_osa0", osa[0], 64'hBEEF_0000);
        chk("post_rst_osc2", osc[2], 64'hBEEF_000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
